// File: rtl/boss_contact_damage.sv
// Player contact damage: once per frame, tests the character box against the
// boss box, removes HP on contact and opens a frame-counted invulnerability
// window. All outputs are registered.
module boss_contact_damage #(
    parameter int         CHAR_HGT    = 64,
    parameter int         CHAR_LNG    = 48,
    parameter logic [6:0] CHAR_HP_MAX = 7'd10,
    parameter logic [6:0] CONTACT_DMG = 7'd1,
    parameter int         IFRAMES     = 60,
    parameter logic [1:0] PLAY        = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic        game_start,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic [11:0] boss_hgt,
    input  logic [11:0] boss_lng,
    input  logic [6:0]  boss_hp,
    output logic [6:0]  char_hp,
    output logic        hit_pulse,
    output logic        invuln,
    output logic        char_dead
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_INVULN,
        S_DEAD
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  char_hp_q, char_hp_d;
    logic [7:0]  ifr_cnt_q, ifr_cnt_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        invuln_q, invuln_d;
    logic        char_dead_q, char_dead_d;
    logic        overlap_q, overlap_d;

    logic [12:0] dx, dy;
    logic [13:0] two_dx, two_dy, lng_sum, hgt_sum;
    logic        playing;
    logic        boss_alive;

    assign playing    = (game_active == PLAY);
    assign boss_alive = (boss_hp != 7'd0);

    // Box overlap on centre distances; subtracting the smaller coordinate
    // keeps the distance exact instead of wrapping at the 12-bit boundary.
    always_comb begin
        dx      = (char_x >= boss_x) ? {1'b0, char_x - boss_x} : {1'b0, boss_x - char_x};
        dy      = (char_y >= boss_y) ? {1'b0, char_y - boss_y} : {1'b0, boss_y - char_y};
        two_dx  = {dx, 1'b0};
        two_dy  = {dy, 1'b0};
        lng_sum = 14'(CHAR_LNG) + {2'b00, boss_lng};
        hgt_sum = 14'(CHAR_HGT) + {2'b00, boss_hgt};
        // Strict compare: boxes whose edges just touch are not in contact.
        overlap_d = (two_dx < lng_sum) && (two_dy < hgt_sum);
    end

    // Next-state for the damage FSM; game_start outranks everything else.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned, which would infer a latch.
        state_d     = state_q;
        char_hp_d   = char_hp_q;
        ifr_cnt_d   = ifr_cnt_q;
        hit_pulse_d = 1'b0;

        if (game_start) begin
            state_d   = S_ARMED;
            char_hp_d = CHAR_HP_MAX;
            ifr_cnt_d = 8'd0;
        end else if (playing) begin
            unique case (state_q)
                S_IDLE: ;
                S_ARMED: begin
                    if (frame_tick && overlap_q && boss_alive) begin
                        char_hp_d   = (char_hp_q > CONTACT_DMG) ? char_hp_q - CONTACT_DMG : 7'd0;
                        hit_pulse_d = 1'b1;
                        if (char_hp_d == 7'd0) begin
                            state_d = S_DEAD;
                        end else begin
                            state_d   = S_INVULN;
                            ifr_cnt_d = 8'(IFRAMES);
                        end
                    end
                end
                S_INVULN: begin
                    if (frame_tick) begin
                        ifr_cnt_d = ifr_cnt_q - 8'd1;
                        if (ifr_cnt_q == 8'd1) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_DEAD: ;
                default: state_d = S_IDLE;
            endcase
        end

        invuln_d    = (state_d == S_INVULN);
        char_dead_d = (state_d == S_DEAD);
    end

    // State, counters and registered outputs; reset applies asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            char_hp_q   <= CHAR_HP_MAX;
            ifr_cnt_q   <= 8'd0;
            hit_pulse_q <= 1'b0;
            invuln_q    <= 1'b0;
            char_dead_q <= 1'b0;
            overlap_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            state_q     <= state_d;
            char_hp_q   <= char_hp_d;
            ifr_cnt_q   <= ifr_cnt_d;
            hit_pulse_q <= hit_pulse_d;
            invuln_q    <= invuln_d;
            char_dead_q <= char_dead_d;
            overlap_q   <= overlap_d;
        end
    end

    assign char_hp   = char_hp_q;
    assign hit_pulse = hit_pulse_q;
    assign invuln    = invuln_q;
    assign char_dead = char_dead_q;

endmodule

// File: tb/tb_boss_contact_damage.sv
// Bench for boss_contact_damage: two instances (contact damage 1 and 3) share
// stimulus and are compared every cycle against a frame-level reference model.
module tb_boss_contact_damage;

    localparam int         IFR  = 60;
    localparam logic [1:0] PLAY = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick, game_start;
    logic [1:0]  game_active;
    logic [11:0] char_x, char_y, boss_x, boss_y, boss_hgt, boss_lng;
    logic [6:0]  boss_hp;
    logic [6:0]  char_hp1, char_hp3;
    logic        hit1, hit3, inv1, inv3, dead1, dead3;

    always #5 clk = ~clk;

    boss_contact_damage u_dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .game_start(game_start), .char_x(char_x), .char_y(char_y),
        .boss_x(boss_x), .boss_y(boss_y), .boss_hgt(boss_hgt), .boss_lng(boss_lng),
        .boss_hp(boss_hp), .char_hp(char_hp1), .hit_pulse(hit1), .invuln(inv1),
        .char_dead(dead1)
    );

    boss_contact_damage #(.CONTACT_DMG(7'd3)) u_dut3 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .game_start(game_start), .char_x(char_x), .char_y(char_y),
        .boss_x(boss_x), .boss_y(boss_y), .boss_hgt(boss_hgt), .boss_lng(boss_lng),
        .boss_hp(boss_hp), .char_hp(char_hp3), .hit_pulse(hit3), .invuln(inv3),
        .char_dead(dead3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: counts played frame ticks since the last hit instead of
    // tracking any FSM; a hit is allowed once IFR ticks have elapsed.
    typedef struct {
        bit started;
        int hp;
        int since;
        bit hit;
        bit prev_contact;
    } model_t;

    model_t m1, m3;

    function automatic bit contact_now();
        int ddx, ddy;
        ddx = int'(char_x) - int'(boss_x);
        ddy = int'(char_y) - int'(boss_y);
        if (ddx < 0) ddx = -ddx;
        if (ddy < 0) ddy = -ddy;
        return (2 * ddx < 48 + int'(boss_lng)) && (2 * ddy < 64 + int'(boss_hgt));
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.started = 0; m.hp = 10; m.since = IFR; m.hit = 0; m.prev_contact = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m_in, input int dmg);
        model_t m;
        if (!rst) return model_reset();
        m = m_in;
        m.hit = 0;
        if (game_start) begin
            m.started = 1; m.hp = 10; m.since = IFR;
        end else if (game_active == PLAY && frame_tick && m.started && m.hp > 0) begin
            if (m.since < IFR) begin
                m.since++;
            end else if (m.prev_contact && boss_hp != 0) begin
                m.hp    = (m.hp > dmg) ? m.hp - dmg : 0;
                m.hit   = 1;
                m.since = 0;
            end
        end
        m.prev_contact = contact_now();
        return m;
    endfunction

    function automatic int exp_inv(input model_t m);
        return int'(m.started && m.hp > 0 && m.since < IFR);
    endfunction

    function automatic int exp_dead(input model_t m);
        return int'(m.started && m.hp == 0);
    endfunction

    task automatic compare_all();
        check("d1_hp", int'(char_hp1), m1.hp);
        check("d1_hit", int'(hit1), int'(m1.hit));
        check("d1_invuln", int'(inv1), exp_inv(m1));
        check("d1_dead", int'(dead1), exp_dead(m1));
        check("d3_hp", int'(char_hp3), m3.hp);
        check("d3_hit", int'(hit3), int'(m3.hit));
        check("d3_invuln", int'(inv3), exp_inv(m3));
        check("d3_dead", int'(dead3), exp_dead(m3));
    endtask

    // One clock: model advances on the same inputs the DUT samples; outputs
    // are compared 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        m1 = model_step(m1, 1);
        m3 = model_step(m3, 3);
        #1;
        compare_all();
    endtask

    task automatic tick(output bit h1, output bit h3);
        frame_tick = 1'b1;
        step();
        h1 = hit1; h3 = hit3;
        frame_tick = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic set_pos(input int cx, input int cy, input int bx, input int by,
                           input int bl, input int bh);
        char_x = 12'(cx); char_y = 12'(cy); boss_x = 12'(bx); boss_y = 12'(by);
        boss_lng = 12'(bl); boss_hgt = 12'(bh);
    endtask

    task automatic count_to_hit(output int n);
        bit h1, h3;
        n = 0; h1 = 0;
        while (!h1 && n < 200) begin
            tick(h1, h3);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_hp_now", int'(char_hp1), 10);
        check("rst_invuln_now", int'(inv1), 0);
        check("rst_dead_now", int'(dead3), 0);
        check("rst_hit_now", int'(hit1), 0);
        m1 = model_reset();
        m3 = model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        int         cx, cy, bx, by, bl, bh;
        logic [6:0] bhp;
        logic [1:0] ga;
        bit         exp_hit;
        int         exp_hp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h1, h3;
        int n, k;
        int hp_seq[$];
        int exp_seq[4];
        int late_hits;

        vecs[0]  = '{400, 300, 420, 300, 106, 95, 7'd50, PLAY,  1, 9};
        vecs[1]  = '{400, 300, 477, 300, 106, 95, 7'd50, PLAY,  0, 10};
        vecs[2]  = '{400, 300, 476, 300, 106, 95, 7'd50, PLAY,  1, 9};
        vecs[3]  = '{400, 300, 324, 300, 106, 95, 7'd50, PLAY,  1, 9};
        vecs[4]  = '{400, 300, 323, 300, 106, 95, 7'd50, PLAY,  0, 10};
        vecs[5]  = '{400, 300, 400, 379, 106, 95, 7'd50, PLAY,  1, 9};
        vecs[6]  = '{400, 300, 400, 380, 106, 95, 7'd50, PLAY,  0, 10};
        vecs[7]  = '{400, 300, 420, 300, 106, 95, 7'd0,  PLAY,  0, 10};
        vecs[8]  = '{400, 300, 420, 300, 106, 95, 7'd50, 2'b10, 0, 10};
        vecs[9]  = '{0,   300, 4095, 300, 4095, 95, 7'd50, PLAY, 0, 10};
        vecs[10] = '{0,   0,   2000, 2000, 4095, 4095, 7'd50, PLAY, 1, 9};

        rst = 1'b0; frame_tick = 0; game_start = 0; game_active = 2'b00; boss_hp = 7'd50;
        set_pos(0, 0, 1000, 1000, 50, 50);
        m1 = model_reset(); m3 = model_reset();
        step();
        check("reset_hp", int'(char_hp1), 10);
        check("reset_invuln", int'(inv1), 0);
        check("reset_dead", int'(dead1), 0);
        step();
        rst = 1'b1;

        // IDLE ignores contact until game_start
        game_active = PLAY;
        set_pos(400, 300, 420, 300, 106, 95);
        repeat (3) tick(h1, h3);
        check("idle_hp", int'(char_hp1), 10);

        // Single hit
        pulse_start();
        step();
        tick(h1, h3);
        check("single_hit", int'(h1), 1);
        check("single_hp", int'(char_hp1), 9);
        check("single_invuln", int'(inv1), 1);
        check("single_pulse_width", int'(hit1), 0);

        // Invulnerability window with overlap held
        count_to_hit(n);
        check("window_gap", n, 61);
        check("window_hp", int'(char_hp1), 8);

        // Window paused by a non-play mode for 5 ticks
        n = 0;
        repeat (20) tick(h1, h3);
        n += 20;
        game_active = 2'b10;
        repeat (5) tick(h1, h3);
        n += 5;
        game_active = PLAY;
        count_to_hit(k);
        check("paused_gap", n + k, 66);
        check("paused_hp", int'(char_hp1), 7);

        // Reset in the middle of INVULN, then IDLE holds HP
        repeat (3) tick(h1, h3);
        do_reset();
        repeat (3) tick(h1, h3);
        check("reset_idle_hp", int'(char_hp1), 10);

        // Table of box geometry vectors
        foreach (vecs[i]) begin
            set_pos(vecs[i].cx, vecs[i].cy, vecs[i].bx, vecs[i].by, vecs[i].bl, vecs[i].bh);
            boss_hp = vecs[i].bhp;
            game_active = vecs[i].ga;
            pulse_start();
            step();
            tick(h1, h3);
            check($sformatf("vec%0d_hit", i), int'(h1), int'(vecs[i].exp_hit));
            check($sformatf("vec%0d_hp", i), int'(char_hp1), vecs[i].exp_hp);
            game_active = PLAY;
        end

        // Death with 3 damage per hit
        set_pos(400, 300, 420, 300, 106, 95);
        boss_hp = 7'd50;
        pulse_start();
        step();
        n = 0;
        while (!dead3 && n < 400) begin
            tick(h1, h3);
            if (h3) hp_seq.push_back(int'(char_hp3));
            n++;
        end
        exp_seq = '{7, 4, 1, 0};
        check("death_hits", hp_seq.size(), 4);
        foreach (exp_seq[i])
            if (i < hp_seq.size()) check($sformatf("death_hp%0d", i), hp_seq[i], exp_seq[i]);
        check("death_flag", int'(dead3), 1);
        late_hits = 0;
        repeat (5) begin
            tick(h1, h3);
            if (h3) late_hits++;
        end
        check("dead_no_pulse", late_hits, 0);

        // game_start re-arms from DEAD
        pulse_start();
        check("rearm_hp", int'(char_hp3), 10);
        check("rearm_dead", int'(dead3), 0);
        step();
        tick(h1, h3);
        check("rearm_armed_hit", int'(h3), 1);
        check("rearm_armed_hp", int'(char_hp3), 7);

        // game_start in the same cycle as a qualifying tick wins
        pulse_start();
        step();
        frame_tick = 1'b1; game_start = 1'b1;
        step();
        check("prio_hit", int'(hit1), 0);
        check("prio_hp", int'(char_hp1), 10);
        check("prio_hp3", int'(char_hp3), 10);
        frame_tick = 1'b0; game_start = 1'b0;
        step();
        tick(h1, h3);
        check("prio_then_hit", int'(char_hp1), 9);

        // Randomized traffic against the model
        pulse_start();
        for (int i = 0; i < 4000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            game_start = ($urandom_range(0, 299) == 0);
            k = $urandom_range(0, 7);
            game_active = (k == 0) ? 2'b10 : (k == 1) ? 2'b00 : PLAY;
            if ($urandom_range(0, 99) == 0) boss_hp = (boss_hp == 7'd0) ? 7'd50 : 7'd0;
            set_pos(300 + $urandom_range(0, 200), 300 + $urandom_range(0, 200),
                    300 + $urandom_range(0, 200), 300 + $urandom_range(0, 200),
                    $urandom_range(20, 150), $urandom_range(20, 150));
            if (i == 2000) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
